// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers stereo pairs in a small FIFO and shifts them out
// MSB-first on DACDAT, timed by codec-driven BCLK/DACLRCK synchronized into clk_clk.
module audio_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          audio_interface_BCLK,
    input  logic                          audio_interface_DACLRCK,
    output logic                          audio_interface_DACDAT,
    input  logic [DATA_WIDTH-1:0]         sink_data_left,
    input  logic [DATA_WIDTH-1:0]         sink_data_right,
    input  logic                          sink_valid,
    output logic                          sink_ready,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    // Sink handshake: a pair transfers on any rising clk_clk edge where
    // sink_valid && sink_ready; sink_valid may not depend on sink_ready.
    logic [2:0]              bclk_sync_q;
    logic [1:0]              lrck_sync_q;
    logic                    lrck_prev_q;
    state_t                  state_q, state_d;
    logic                    chan_q, chan_d;
    logic [DATA_WIDTH-1:0]   hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0]   hold_right_q, hold_right_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           bitcnt_q, bitcnt_d;
    logic                    dacdat_q, dacdat_d;
    logic                    underrun_q, underrun_d;
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                    bclk_fall, lrck_now, lrck_edge, left_start;
    logic                    empty, full, push, pop;
    logic [AW:0]             level;
    logic [2*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]   word;

    assign bclk_fall  = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lrck_now   = lrck_sync_q[1];
    assign lrck_edge  = bclk_fall && (lrck_now != lrck_prev_q);
    assign left_start = lrck_edge && !lrck_now;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign empty      = (level == '0);
    assign full       = (level == (AW+1)'(FIFO_DEPTH));
    assign sink_ready = !full && !reset_reset;
    assign push       = sink_valid && sink_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign word       = chan_q ? hold_right_q : hold_left_q;

    assign audio_interface_DACDAT = dacdat_q;
    assign underrun               = underrun_q;
    assign fifo_level             = level;
    assign dbg_state              = state_q;

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        dacdat_d     = dacdat_q;
        underrun_d   = 1'b0;
        pop          = 1'b0;
        if (bclk_fall) begin
            // A channel start preempts whatever is in flight; ALIGN waits for a left start only.
            if ((state_q == ST_ALIGN) ? left_start : lrck_edge) begin
                state_d  = ST_LOAD;
                dacdat_d = 1'b0;
                chan_d   = lrck_now;
                if (!lrck_now) begin
                    if (empty) begin
                        hold_left_d  = '0;
                        hold_right_d = '0;
                        underrun_d   = 1'b1;
                    end else begin
                        pop          = 1'b1;
                        hold_left_d  = head[2*DATA_WIDTH-1:DATA_WIDTH];
                        hold_right_d = head[DATA_WIDTH-1:0];
                    end
                end
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        shift_d  = word;
                        dacdat_d = word[DATA_WIDTH-1];
                        bitcnt_d = CW'(DATA_WIDTH-1);
                        state_d  = ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (bitcnt_q == '0) begin
                            dacdat_d = 1'b0;
                            state_d  = ST_PAD;
                        end else begin
                            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            dacdat_d = shift_q[DATA_WIDTH-2];
                            bitcnt_d = bitcnt_q - CW'(1);
                        end
                    end
                    default: dacdat_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            lrck_prev_q  <= 1'b0;
            state_q      <= ST_ALIGN;
            chan_q       <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            dacdat_q     <= 1'b0;
            underrun_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[1:0], audio_interface_BCLK};
            lrck_sync_q  <= {lrck_sync_q[0], audio_interface_DACLRCK};
            if (bclk_fall) begin
                lrck_prev_q <= lrck_now;
            end
            state_q      <= state_d;
            chan_q       <= chan_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            dacdat_q     <= dacdat_d;
            underrun_q   <= underrun_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: emptiness is defined purely by the pointers.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sink_data_left, sink_data_right};
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: drives BCLK = clk/16 with 32 slots per channel
// and captures DACDAT on each BCLK rising edge, comparing whole slot words.
module tb_audio_dac_tx;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bclk, lrck, dacdat, sink_valid, sink_ready, underrun;
  logic [W-1:0] dl, dr;
  logic [2:0] level;
  logic [1:0] dbg;

  audio_dac_tx #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk_clk                (clk),
    .reset_reset            (rst),
    .audio_interface_BCLK   (bclk),
    .audio_interface_DACLRCK(lrck),
    .audio_interface_DACDAT (dacdat),
    .sink_data_left         (dl),
    .sink_data_right        (dr),
    .sink_valid             (sink_valid),
    .sink_ready             (sink_ready),
    .underrun               (underrun),
    .fifo_level             (level),
    .dbg_state              (dbg)
  );

  int checks = 0;
  int failures = 0;

  // underrun pulse monitor: counts rising edges and cycles where it stayed high
  int ur_pulses = 0;
  int ur_long = 0;
  logic ur_prev = 1'b0;
  always @(posedge clk) begin
    ur_prev <= underrun;
    if (underrun && !ur_prev) ur_pulses <= ur_pulses + 1;
    if (underrun && ur_prev) ur_long <= ur_long + 1;
  end

  logic [2:0] lvl_after_start, lvl_push, lvl_after_rst, lvl_at_accept;
  logic dac_before_rst, dac_after_rst;
  bit pend, pend_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fr(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  // One BCLK period: 8 clk low, then rising edge (DACDAT captured), 8 clk high.
  task automatic slot(input logic lr, input bit do_push, input logic [15:0] pl,
                      input logic [15:0] pr, input bit do_rst, output logic b);
    @(negedge clk);
    bclk = 1'b0;
    lrck = lr;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pend_drop) begin sink_valid = 1'b0; pend_drop = 1'b0; end
      if (pend && sink_ready) begin pend = 1'b0; pend_drop = 1'b1; lvl_at_accept = level; end
      if (do_push && i == 2) begin dl = pl; dr = pr; sink_valid = 1'b1; end
      if (do_push && i == 3) begin sink_valid = 1'b0; lvl_push = level; end
      if (do_rst && i == 5) begin dac_before_rst = dacdat; rst = 1'b1; end
      if (do_rst && i == 6) begin dac_after_rst = dacdat; lvl_after_rst = level; end
      if (do_rst && i == 7) rst = 1'b0;
    end
    bclk = 1'b1;
    b = dacdat;
    for (int i = 1; i <= 7; i++) @(negedge clk);
  endtask

  task automatic frame(input bit do_push, input logic [15:0] pl, input logic [15:0] pr,
                       input bit do_rst, output logic [31:0] lb, output logic [31:0] rb);
    logic b;
    lb = '0;
    rb = '0;
    for (int s = 0; s < 32; s++) begin
      slot(1'b0, do_push && s == 0, pl, pr, do_rst && s == 8, b);
      lb = {lb[30:0], b};
      if (s == 0) lvl_after_start = level;
    end
    for (int s = 0; s < 32; s++) begin
      slot(1'b1, 1'b0, pl, pr, 1'b0, b);
      rb = {rb[30:0], b};
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    dl = l;
    dr = r;
    sink_valid = 1'b1;
    @(negedge clk);
    sink_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] lb, rb;
    logic b;
    logic [15:0] pl [5];
    logic [15:0] pr [5];
    int base_p, base_l;

    pl[0] = 16'hC3A5; pr[0] = 16'h5A3C;
    pl[1] = 16'h8001; pr[1] = 16'h7FFE;
    pl[2] = 16'hFFFF; pr[2] = 16'h0001;
    pl[3] = 16'h2DB6; pr[3] = 16'h4924;
    pl[4] = 16'h1357; pr[4] = 16'h9BDF;

    rst = 1'b1; bclk = 1'b1; lrck = 1'b1; sink_valid = 1'b0; dl = '0; dr = '0;
    pend = 1'b0; pend_drop = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    check("rst_ready_low", 32'(sink_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_high", 32'(sink_ready), 32'd1);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // right-channel preamble so the first frame starts on a clean left start
    slot(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, b);
    slot(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, b);
    check("align_dacdat", 32'(b), 32'd0);

    // single frame
    base_p = ur_pulses;
    push_pair(16'hA5F0, 16'h0F0F);
    check("single_level_pre", 32'(level), 32'd1);
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("single_left", lb, fr(16'hA5F0));
    check("single_right", rb, fr(16'h0F0F));
    check("single_level_start", 32'(lvl_after_start), 32'd0);
    check("single_no_underrun", 32'(ur_pulses - base_p), 32'd0);

    // underrun
    base_p = ur_pulses;
    base_l = ur_long;
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("ur_left", lb, 32'd0);
    check("ur_right", rb, 32'd0);
    check("ur_pulses", 32'(ur_pulses - base_p), 32'd1);
    check("ur_width", 32'(ur_long - base_l), 32'd0);

    // full FIFO: four pushes fill it, fifth stays pending until a left start
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("full_ready_%0d", k), 32'(sink_ready), 32'd1);
      dl = pl[k];
      dr = pr[k];
      sink_valid = 1'b1;
    end
    @(negedge clk);
    check("full_ready_drop", 32'(sink_ready), 32'd0);
    check("full_level", 32'(level), 32'd4);
    dl = pl[4];
    dr = pr[4];
    repeat (4) @(negedge clk);
    check("full_level_hold", 32'(level), 32'd4);
    check("full_ready_hold", 32'(sink_ready), 32'd0);
    pend = 1'b1;
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("full_accept_level", 32'(lvl_at_accept), 32'd3);
    check("full_pend_done", 32'(pend), 32'd0);
    check("full_left_p0", lb, fr(pl[0]));
    check("full_right_p0", rb, fr(pr[0]));
    check("full_level_after", 32'(level), 32'd4);

    // drain two pairs in order
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("order_left_p1", lb, fr(pl[1]));
    check("order_right_p1", rb, fr(pr[1]));
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("order_left_p2", lb, fr(pl[2]));
    check("order_right_p2", rb, fr(pr[2]));
    check("order_level", 32'(level), 32'd2);

    // reset during left-slot bit 8 of P3 (bit 8 of 16'h2DB6 is 1)
    frame(1'b0, 16'h0, 16'h0, 1'b1, lb, rb);
    check("mid_rst_dac_before", 32'(dac_before_rst), 32'd1);
    check("mid_rst_dac_after", 32'(dac_after_rst), 32'd0);
    check("mid_rst_level", 32'(lvl_after_rst), 32'd0);
    check("mid_rst_left", lb, 32'h1600_0000);
    check("mid_rst_right", rb, 32'd0);
    check("mid_rst_level_end", 32'(level), 32'd0);

    // transmission resumes at the next left start
    push_pair(16'h6C39, 16'hE1E1);
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("resume_left", lb, fr(16'h6C39));
    check("resume_right", rb, fr(16'hE1E1));

    // push in the same cycle as the left-start pop
    push_pair(16'h4B1D, 16'hD1B4);
    check("simul_level_pre", 32'(level), 32'd1);
    frame(1'b1, 16'h7E81, 16'h81E7, 1'b0, lb, rb);
    check("simul_level_same", 32'(lvl_push), 32'd1);
    check("simul_left_old", lb, fr(16'h4B1D));
    check("simul_right_old", rb, fr(16'hD1B4));
    frame(1'b0, 16'h0, 16'h0, 1'b0, lb, rb);
    check("simul_left_new", lb, fr(16'h7E81));
    check("simul_right_new", rb, fr(16'h81E7));
    check("simul_level_end", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
